// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if -- operand/result handshake bundle for seq_alu.
//
// Input side : in_valid, in_ready, a, b, m (4-bit opcode)
// Output side: out_valid, out_ready, y, zf, cf, of, ill
//
// The WIDTH parameter must match the WIDTH of the seq_alu it connects to.
// Modports:
//   master - the operand producer / result consumer (drives a, b, m,
//            in_valid, out_ready)
//   slave  - the ALU itself
// ---------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       m;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zf;
  logic             cf;
  logic             of;
  logic             ill;

  modport master (
    output in_valid, a, b, m, out_ready,
    input  in_ready, out_valid, y, zf, cf, of, ill
  );

  modport slave (
    input  in_valid, a, b, m, out_ready,
    output in_ready, out_valid, y, zf, cf, of, ill
  );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- registered, valid/ready handshaked ALU.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - seq_alu_if.slave: in_valid/in_ready/a/b/m on the operand side,
//            out_valid/out_ready/y/zf/cf/of/ill on the result side
//
// Single-cycle ops (add, sub, and, or, xor, sll, srl, sra, slt, sltu) are
// written straight into a one-entry output register. Unknown opcodes produce
// y=0, ill=1 with the same latency.
//
// Build option: define SEQ_ALU_MUL_EN to make opcode 1010 an iterative
// shift-add multiplier (WIDTH iterations, input side stalled). Without it,
// 1010 is illegal and no multiplier state exists.
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_alu_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010
  } op_e;

  logic             slot_free;
  logic             accept;
  logic             is_mul;
  logic             load_alu;
  logic             load_mul;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cf;
  logic             alu_of;
  logic             alu_ill;

  logic [WIDTH-1:0] mul_y;
  logic             mul_ovf;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             ill_q, ill_d;
  logic             zf_q;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;
  assign shamt     = bus.b[SHW-1:0];
  // Carry/borrow fall out of the extra top bit of a WIDTH+1 add/subtract.
  assign sum_w     = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_w    = {1'b0, bus.a} - {1'b0, bus.b};

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_y   = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_ill = 1'b0;
    case (bus.m)
      OP_ADD: begin
        alu_y  = sum_w[WIDTH-1:0];
        alu_cf = sum_w[WIDTH];
        alu_of = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                 (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y  = diff_w[WIDTH-1:0];
        alu_cf = diff_w[WIDTH];
        alu_of = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                 (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_y = bus.a & bus.b;
      OP_OR:   alu_y = bus.a | bus.b;
      OP_XOR:  alu_y = bus.a ^ bus.b;
      OP_SLL:  alu_y = bus.a << shamt;
      OP_SRL:  alu_y = bus.a >> shamt;
      OP_SRA:  alu_y = WIDTH'($signed(bus.a) >>> shamt);
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  alu_ill = 1'b0;  // result comes from the multiplier path
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  // ---------------------------------------------------------------------
  // Iterative shift-add multiplier
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  assign is_mul       = (bus.m == OP_MUL);
  assign bus.in_ready = (state_q == S_IDLE) && slot_free;
  assign load_mul     = (state_q == S_DONE) && slot_free;
  assign mul_y        = acc_q[WIDTH-1:0];
  assign mul_ovf      = |acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // cnt_q counts completed iterations; this is the WIDTH-th one.
        if (cnt_q == SHW'(WIDTH-1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (slot_free) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign is_mul       = 1'b0;
  assign bus.in_ready = slot_free;
  assign load_mul     = 1'b0;
  assign mul_y        = '0;
  assign mul_ovf      = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // One-entry output register
  // ---------------------------------------------------------------------
  assign load_alu = accept && !is_mul;

  always_comb begin
    // A load in the same cycle as a consume keeps the slot full.
    out_valid_d = load_alu || load_mul || (out_valid_q && !bus.out_ready);
    y_d   = y_q;
    cf_d  = cf_q;
    of_d  = of_q;
    ill_d = ill_q;
    if (load_mul) begin
      y_d   = mul_y;
      cf_d  = mul_ovf;
      of_d  = mul_ovf;
      ill_d = 1'b0;
    end else if (load_alu) begin
      y_d   = alu_y;
      cf_d  = alu_cf;
      of_d  = alu_of;
      ill_d = alu_ill;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zf_q        <= (y_d == '0);
      cf_q        <= cf_d;
      of_q        <= of_d;
      ill_q       <= ill_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zf        = zf_q;
  assign bus.cf        = cf_q;
  assign bus.of        = of_q;
  assign bus.ill       = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- directed, table-driven bench for seq_alu at WIDTH=8.
// Inputs are driven on the falling edge; outputs are sampled 1 ns after the
// rising edge. Multiply checks are built only when SEQ_ALU_MUL_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         zf;
    logic         cf;
    logic         of;
    logic         ill;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // {out_valid, zf, cf, of, ill}
  function automatic logic [4:0] flags();
    return {bus.out_valid, bus.zf, bus.cf, bus.of, bus.ill};
  endfunction

  task automatic drive(input logic v, input logic [3:0] m,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rdy);
    bus.in_valid  = v;
    bus.m         = m;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = rdy;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
    end
  endtask

  initial begin
    int seen;
    int stale;

    // ---------------- reset state ----------------
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
    rst_n = 1'b0;
    #12;
    check("rst_y", bus.y, 8'h00);
    check("rst_flags", flags(), 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1'b1);

    // ---------------- vector table ----------------
    vecs.push_back('{4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0}); // add ovf
    vecs.push_back('{4'h1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0}); // sub borrow
    vecs.push_back('{4'h1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0}); // sub ovf
    vecs.push_back('{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}); // add carry
    vecs.push_back('{4'h7, 8'h80, 8'h0B, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0}); // sra 3
    vecs.push_back('{4'h6, 8'h80, 8'h0B, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0}); // srl 3
    vecs.push_back('{4'h5, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0}); // sll 3
    vecs.push_back('{4'h8, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}); // slt
    vecs.push_back('{4'h9, 8'h80, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}); // sltu
    vecs.push_back('{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0}); // and
    vecs.push_back('{4'h3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}); // or
    vecs.push_back('{4'h4, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}); // xor
    vecs.push_back('{4'hF, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}); // illegal
    vecs.push_back('{4'hB, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}); // illegal
`ifndef SEQ_ALU_MUL_EN
    vecs.push_back('{4'hA, 8'h0F, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}); // mul off
`endif

    // Back-to-back streaming: one accept and one result per cycle.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].m, vecs[i].a, vecs[i].b, 1'b1);
      #1 check($sformatf("v%0d_in_ready", i), bus.in_ready, 1'b1);
      @(posedge clk); #1;
      check($sformatf("v%0d_y", i), bus.y, vecs[i].y);
      check($sformatf("v%0d_vzcoi", i), flags(),
            {1'b1, vecs[i].zf, vecs[i].cf, vecs[i].of, vecs[i].ill});
    end
    idle_cycles(2);

`ifdef SEQ_ALU_MUL_EN
    // ---------------- multiply: latency and stall ----------------
    for (int t = 0; t < 2; t++) begin
      logic [W-1:0] ma, mb, my;
      logic         mo;
      ma = (t == 0) ? 8'h0F : 8'h10;
      mb = (t == 0) ? 8'h11 : 8'h10;
      my = (t == 0) ? 8'hFF : 8'h00;
      mo = (t == 0) ? 1'b0  : 1'b1;
      @(negedge clk);
      drive(1'b1, 4'hA, ma, mb, 1'b1);
      @(posedge clk);                       // accept edge k
      seen = 0;
      for (int c = 1; c <= 20 && seen == 0; c++) begin
        @(negedge clk);
        // Operands and opcode change freely while the multiply runs.
        drive(1'b0, 4'h0, 8'($urandom), 8'($urandom), 1'b1);
        @(posedge clk); #1;
        if (bus.out_valid) seen = c;
        else if (bus.in_ready) begin
          check($sformatf("mul%0d_stall_c%0d", t, c), bus.in_ready, 1'b0);
        end
      end
      check($sformatf("mul%0d_latency", t), seen, 9);
      check($sformatf("mul%0d_y", t), bus.y, my);
      check($sformatf("mul%0d_vzcoi", t), flags(),
            {1'b1, (my == 8'h00), mo, mo, 1'b0});
      check($sformatf("mul%0d_ready_after", t), bus.in_ready, 1'b1);
    end
    idle_cycles(2);
`endif

    // ---------------- backpressure ----------------
    @(negedge clk);
    drive(1'b1, 4'h0, 8'h01, 8'h01, 1'b0);
    @(posedge clk); #1;
    check("bp_first_y", bus.y, 8'h02);
    @(negedge clk);
    drive(1'b1, 4'h0, 8'h02, 8'h02, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp_in_ready_c%0d", c), bus.in_ready, 1'b0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_c%0d", c), {bus.out_valid, bus.y}, {1'b1, 8'h02});
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      bus.a = 8'(i);
      bus.b = 8'(i);
      @(posedge clk); #1;
      check($sformatf("bp_stream_%0d", i), {bus.out_valid, bus.y},
            {1'b1, 8'(2 * i)});
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_no_dup", bus.out_valid, 1'b0);

    // ---------------- reset with pending work ----------------
    @(negedge clk);
`ifdef SEQ_ALU_MUL_EN
    drive(1'b1, 4'hA, 8'h0F, 8'h11, 1'b1);   // reset lands mid-multiply
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
`else
    drive(1'b1, 4'h0, 8'h33, 8'h44, 1'b0);   // reset lands on a held result
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
    #1 check("rst2_pending", {bus.out_valid, bus.y}, {1'b1, 8'h77});
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst2_y", bus.y, 8'h00);
    check("rst2_flags", flags(), 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst2_in_ready", bus.in_ready, 1'b1);
    stale = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    check("rst2_no_stale", stale, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
